ex_divider: RTL

- Iterative 32-bit signed/unsigned divider in the EX stage; executes DIV and DIVU.
- Runs in parallel with the single-cycle adder.
- Holds the pipeline through a stall request while it iterates.
- Returns the quotient for LO and the remainder for HI, ready for the HI/LO write in MEM/WB.

---
 rtl/ex_divider_pkg.sv | 21 ++
 rtl/ex_divider_div_step.sv | 34 +++
 rtl/ex_divider.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ex_divider_pkg.sv
// ----------------------------------------------------------------------------
// ex_divider_pkg
// Shared definitions for the EX-stage iterative divider:
//   - function-code width and the DIV / DIVU function codes
//   - divider FSM state encoding
// ----------------------------------------------------------------------------
package ex_divider_pkg;

   localparam int FUNCT_W = 6;

   localparam logic [FUNCT_W-1:0] FUNCT_DIV  = 6'b011010;
   localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ZERO = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/ex_divider_div_step.sv
// ----------------------------------------------------------------------------
// ex_divider_div_step
// One combinational restoring-division step on the {rem, dvd} pair.
// Two of these can be chained for a radix-4 variant.
// Ports:
//   rem       in   WIDTH+1  partial remainder
//   dvd       in   WIDTH    dividend bits still to shift in / quotient bits so far
//   divisor   in   WIDTH    divisor magnitude
//   rem_next  out  WIDTH+1  partial remainder after this step
//   dvd_next  out  WIDTH    dividend shifted left with the new quotient bit in the LSB
// ----------------------------------------------------------------------------
module ex_divider_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] dvd,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] dvd_next
);

   logic [WIDTH+1:0] shifted;
   logic             ge;

   // Compare and subtract one bit wider than the remainder so the test is exact
   // whatever the remainder register holds.
   always_comb begin
      shifted  = {rem, dvd[WIDTH-1]};
      ge       = (shifted >= {2'b00, divisor});
      rem_next = ge ? (WIDTH+1)'(shifted - {2'b00, divisor}) : shifted[WIDTH:0];
      dvd_next = {dvd[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/ex_divider.sv
// ----------------------------------------------------------------------------
// ex_divider
// Iterative 32-bit signed/unsigned divider for the EX stage (DIV / DIVU).
// Quotient goes to LO, remainder to HI. Stalls the front of the pipeline while
// it iterates and pulses ready for one cycle when the result is available.
// Ports:
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active low
//   funct      in   FUNCT_W  FUNCT_DIV = signed, otherwise unsigned
//   div_en     in   1        divide request, held for the whole instruction
//   annul      in   1        flush, abandons any division in progress
//   operand_1  in   WIDTH    dividend
//   operand_2  in   WIDTH    divisor
//   quotient   out  WIDTH    LO result (registered)
//   remainder  out  WIDTH    HI result (registered)
//   ready      out  1        one-cycle result-valid pulse
//   div_zero   out  1        divisor was zero, meaningful while ready=1
//   stall_req  out  1        freeze IF/ID/EX
// ----------------------------------------------------------------------------
module ex_divider
   import ex_divider_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [FUNCT_W-1:0] funct,
   input  logic               div_en,
   input  logic               annul,
   input  logic [WIDTH-1:0]   operand_1,
   input  logic [WIDTH-1:0]   operand_2,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder,
   output logic               ready,
   output logic               div_zero,
   output logic               stall_req
);

   div_state_e       state;
   div_state_e       next_state;
   logic [CNT_W-1:0] counter;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvd_next;
   logic [WIDTH-1:0] divisor_q;
   logic             neg_q;
   logic             neg_r;
   logic             sign_1;
   logic             sign_2;
   logic             last_step;

   // Operand signs only matter for DIV; DIVU treats both operands as magnitudes.
   assign sign_1    = (funct == FUNCT_DIV) & operand_1[WIDTH-1];
   assign sign_2    = (funct == FUNCT_DIV) & operand_2[WIDTH-1];
   assign last_step = (counter == CNT_W'(WIDTH-1));

   ex_divider_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem      (rem_q),
      .dvd      (dvd_q),
      .divisor  (divisor_q),
      .rem_next (rem_next),
      .dvd_next (dvd_next)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, stall request and ready pulse. annul overrides everything and
   // drops stall_req in the same cycle; stall_req is also forced low in reset
   // so every output reads 0 while rst is held.
   always_comb begin
      next_state = state;
      stall_req  = 1'b0;
      ready      = 1'b0;
      if (annul) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               stall_req = div_en & rst;
               if (div_en) begin
                  next_state = (operand_2 == '0) ? ZERO : CALC;
               end
            end
            CALC: begin
               stall_req = rst;
               if (last_step) begin
                  next_state = DONE;
               end
            end
            ZERO: begin
               stall_req  = rst;
               next_state = DONE;
            end
            DONE: begin
               ready      = 1'b1;
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Datapath. Operands are captured as magnitudes so the iteration is always
   // unsigned; signs are reapplied when the result is registered on the way
   // into DONE. The divide-by-zero remainder reapplies neg_r to the captured
   // magnitude, which reproduces the raw dividend.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter   <= '0;
         rem_q     <= '0;
         dvd_q     <= '0;
         divisor_q <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else if (!annul) begin
         case (state)
            IDLE: begin
               if (div_en) begin
                  dvd_q     <= sign_1 ? -operand_1 : operand_1;
                  divisor_q <= sign_2 ? -operand_2 : operand_2;
                  rem_q     <= '0;
                  neg_q     <= sign_1 ^ sign_2;
                  neg_r     <= sign_1;
                  counter   <= '0;
                  div_zero  <= 1'b0;
               end
            end
            CALC: begin
               rem_q   <= rem_next;
               dvd_q   <= dvd_next;
               counter <= counter + CNT_W'(1);
               if (last_step) begin
                  quotient  <= neg_q ? -dvd_next : dvd_next;
                  remainder <= neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
               end
            end
            ZERO: begin
               quotient  <= '1;
               remainder <= neg_r ? -dvd_q : dvd_q;
               div_zero  <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
